// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//
// Parametrised register file for the CPU datapath. It has two registered read
// ports with write-first bypass, an optional hard-wired zero register, and a
// per-register pending (scoreboard) bit that decode uses to stall on
// registers whose producer has not yet written back.
//
// Parameters:
//   DATA_W    width of each register and of the data ports
//   ADDR_W    address width; depth is 2**ADDR_W
//   RESET_VAL reset value of every register (truncated/zero-extended)
//   ZERO_REG  1: register 0 reads 0 and ignores writes and claims
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   write_en/adr/data        write port; the value is visible to a same-edge read
//   read_en                  samples both read ports at the edge
//   read_adr1/2              read addresses
//   read_data1/2             registered read data; holds while read_en is 0
//   read_valid               high for one cycle after each read_en edge
//   busy1/2                  registered pending flag of the register read
//   claim_en/claim_adr       marks a register pending
//   pending                  current pending bit per register (bit i = reg i)
//
// Read handshake: there is no back-pressure. A read presented with read_en=1
// at an edge is always accepted. Its result appears with read_valid=1 for
// exactly the following cycle. busy1/busy2 are meaningful only while
// read_valid=1. Writes and claims are likewise accepted every cycle.

module regfile_scoreboard #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 2,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          ZERO_REG  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        write_adr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     read_en,
  input  logic [ADDR_W-1:0]        read_adr1,
  input  logic [ADDR_W-1:0]        read_adr2,
  output logic [DATA_W-1:0]        read_data1,
  output logic [DATA_W-1:0]        read_data2,
  output logic                     read_valid,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_adr,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] RST_DATA = DATA_W'(RESET_VAL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending_nxt;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1_nxt;
  logic [DATA_W-1:0] rd2_nxt;

  // Writes to the hard-wired zero register are dropped.
  assign wr_ok = write_en && !(ZERO_REG && (write_adr == '0));

  // The clear is applied before the claim, so a claim and a write to the same
  // register at one edge leave the bit set: the new producer wins.
  always_comb begin
    pending_nxt = pending;
    if (write_en) pending_nxt[write_adr] = 1'b0;
    if (claim_en) pending_nxt[claim_adr] = 1'b1;
    if (ZERO_REG) pending_nxt[0] = 1'b0;
  end

  // Write-first bypass: a same-edge write to the read address wins over the
  // stored contents, except for the zero register.
  always_comb begin
    rd1_nxt = mem[read_adr1];
    rd2_nxt = mem[read_adr2];
    if (wr_ok && (write_adr == read_adr1)) rd1_nxt = write_data;
    if (wr_ok && (write_adr == read_adr2)) rd2_nxt = write_data;
    if (ZERO_REG && (read_adr1 == '0)) rd1_nxt = '0;
    if (ZERO_REG && (read_adr2 == '0)) rd2_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (ZERO_REG && (i == 0)) ? '0 : RST_DATA;
      end
      read_data1 <= '0;
      read_data2 <= '0;
      read_valid <= 1'b0;
      busy1      <= 1'b0;
      busy2      <= 1'b0;
      pending    <= '0;
    end else begin
      if (wr_ok) mem[write_adr] <= write_data;
      pending    <= pending_nxt;
      read_valid <= read_en;
      if (read_en) begin
        read_data1 <= rd1_nxt;
        read_data2 <= rd2_nxt;
        // busy reports the pending state after this edge's clear/claim.
        busy1      <= pending_nxt[read_adr1];
        busy2      <= pending_nxt[read_adr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard. Two instances share one stimulus stream: one
// without the zero register (index 0) and one with it (index 1). Both use
// DATA_W=16, ADDR_W=2 and RESET_VAL=16'h00A5.
module tb_regfile_scoreboard;

  localparam logic [15:0] RV = 16'h00A5;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic        write_en = 0, read_en = 0, claim_en = 0;
  logic [1:0]  write_adr = 0, read_adr1 = 0, read_adr2 = 0, claim_adr = 0;
  logic [15:0] write_data = 0;

  // outputs of both instances
  logic [15:0] a_rd1, a_rd2, z_rd1, z_rd2;
  logic        a_rv, a_b1, a_b2, z_rv, z_b1, z_b2;
  logic [3:0]  a_pend, z_pend;

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .RESET_VAL(32'h00A5), .ZERO_REG(1'b0)) dut (
    .clk(clk), .reset(reset),
    .write_en(write_en), .write_adr(write_adr), .write_data(write_data),
    .read_en(read_en), .read_adr1(read_adr1), .read_adr2(read_adr2),
    .read_data1(a_rd1), .read_data2(a_rd2), .read_valid(a_rv),
    .busy1(a_b1), .busy2(a_b2),
    .claim_en(claim_en), .claim_adr(claim_adr), .pending(a_pend));

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(2), .RESET_VAL(32'h00A5), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset(reset),
    .write_en(write_en), .write_adr(write_adr), .write_data(write_data),
    .read_en(read_en), .read_adr1(read_adr1), .read_adr2(read_adr2),
    .read_data1(z_rd1), .read_data2(z_rd2), .read_valid(z_rv),
    .busy1(z_b1), .busy2(z_b2),
    .claim_en(claim_en), .claim_adr(claim_adr), .pending(z_pend));

  // behavioural model, one slot per instance
  logic [15:0] m_reg  [2][4];
  logic [3:0]  m_pend [2];
  logic [15:0] m_rd1  [2];
  logic [15:0] m_rd2  [2];
  logic        m_rv   [2];
  logic        m_b1   [2];
  logic        m_b2   [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < 4; r++) m_reg[z][r] = (z == 1 && r == 0) ? 16'h0 : RV;
      m_pend[z] = 4'b0;
      m_rd1[z] = 16'h0; m_rd2[z] = 16'h0;
      m_rv[z] = 1'b0; m_b1[z] = 1'b0; m_b2[z] = 1'b0;
    end
  endtask

  // Value a read of register r returns at the edge under the current inputs.
  function automatic logic [15:0] model_read(input int z, input logic [1:0] r);
    if (z == 1 && r == 2'd0) return 16'h0;
    if (write_en && write_adr == r) return write_data;
    return m_reg[z][r];
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    logic [3:0] p;
    for (int z = 0; z < 2; z++) begin
      p = m_pend[z];
      if (write_en) p[write_adr] = 1'b0;
      if (claim_en) p[claim_adr] = 1'b1;
      if (z == 1) p[0] = 1'b0;
      m_rv[z] = read_en;
      if (read_en) begin
        m_rd1[z] = model_read(z, read_adr1);
        m_rd2[z] = model_read(z, read_adr2);
        m_b1[z] = p[read_adr1];
        m_b2[z] = p[read_adr2];
      end
      if (write_en && !(z == 1 && write_adr == 2'd0)) m_reg[z][write_adr] = write_data;
      m_pend[z] = p;
    end
  endtask

  // compare process: all outputs of both instances against the model
  task automatic compare_all();
    check("a_read_data1", a_rd1, m_rd1[0]);
    check("a_read_data2", a_rd2, m_rd2[0]);
    check("a_read_valid", a_rv,  m_rv[0]);
    check("a_pending",    a_pend, m_pend[0]);
    check("z_read_data1", z_rd1, m_rd1[1]);
    check("z_read_data2", z_rd2, m_rd2[1]);
    check("z_read_valid", z_rv,  m_rv[1]);
    check("z_pending",    z_pend, m_pend[1]);
    if (m_rv[0]) begin
      check("a_busy1", a_b1, m_b1[0]);
      check("a_busy2", a_b2, m_b2[0]);
    end
    if (m_rv[1]) begin
      check("z_busy1", z_b1, m_b1[1]);
      check("z_busy2", z_b2, m_b2[1]);
    end
  endtask

  // driver tasks: inputs change at the falling edge
  task automatic set_in(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                        input logic re, input logic [1:0] r1, input logic [1:0] r2,
                        input logic ce, input logic [1:0] ca);
    write_en = we; write_adr = wa; write_data = wd;
    read_en = re; read_adr1 = r1; read_adr2 = r2;
    claim_en = ce; claim_adr = ca;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_rd1"}, a_rd1, 16'h0);
    check({tag, "_a_rv"},  a_rv, 1'b0);
    check({tag, "_a_b1"},  a_b1, 1'b0);
    check({tag, "_a_pend"}, a_pend, 4'b0);
    check({tag, "_z_rd2"}, z_rd2, 16'h0);
    check({tag, "_z_pend"}, z_pend, 4'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // reset values visible through both ports
    set_in(0, 0, 0, 1, 2'd0, 2'd1, 0, 0); cycle();
    check("rst_rd1", a_rd1, 16'h00A5);
    check("rst_rd2", a_rd2, 16'h00A5);
    check("rst_z_rd1", z_rd1, 16'h0000);
    check("rst_rv", a_rv, 1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("rv_drop", a_rv, 1'b0);

    // write then read, then hold
    set_in(1, 2'd2, 16'hBEEF, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 1, 2'd2, 2'd3, 0, 0); cycle();
    check("wr_rd1", a_rd1, 16'hBEEF);
    check("wr_rd2", a_rd2, 16'h00A5);
    set_in(0, 0, 0, 0, 2'd0, 2'd0, 0, 0); cycle();
    check("hold_rd1", a_rd1, 16'hBEEF);
    check("hold_rv", a_rv, 1'b0);

    // bypass
    set_in(1, 2'd1, 16'h1234, 1, 2'd1, 2'd1, 0, 0); cycle();
    check("byp_rd1", a_rd1, 16'h1234);
    check("byp_rd2", a_rd2, 16'h1234);

    // scoreboard
    set_in(0, 0, 0, 0, 0, 0, 1, 2'd3); cycle();
    check("claim_pend", a_pend, 4'b1000);
    set_in(0, 0, 0, 1, 2'd3, 2'd0, 0, 0); cycle();
    check("claim_busy1", a_b1, 1'b1);
    set_in(1, 2'd3, 16'h0F0F, 1, 2'd3, 2'd3, 0, 0); cycle();
    check("wb_rd1", a_rd1, 16'h0F0F);
    check("wb_busy1", a_b1, 1'b0);
    check("wb_pend", a_pend, 4'b0000);
    set_in(1, 2'd3, 16'h5555, 0, 0, 0, 1, 2'd3); cycle();
    check("cw_pend", a_pend, 4'b1000);

    // zero register
    set_in(1, 2'd0, 16'hFFFF, 1, 2'd0, 2'd0, 1, 2'd0); cycle();
    check("zr_rd1", z_rd1, 16'h0000);
    check("zr_busy1", z_b1, 1'b0);
    check("zr_pend", z_pend, 4'b1000);
    check("nz_rd1", a_rd1, 16'hFFFF);
    check("nz_pend", a_pend, 4'b1001);
    set_in(1, 2'd1, 16'hFFFF, 1, 2'd0, 2'd1, 0, 0); cycle();
    check("zr1_rd2", z_rd2, 16'hFFFF);
    check("zr1_rd1", z_rd1, 16'h0000);

    // randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 1), 2'($urandom_range(0, 3)), 16'($urandom),
             $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
      if (n == 200) begin
        set_in(1, 2'd2, 16'h7777, 1, 2'd1, 2'd2, 1, 2'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("async_hold");
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, 1, 2'd2, 2'd1, 0, 0); cycle();
        check("post_rst_rd1", a_rd1, 16'h00A5);
        check("post_rst_rd2", a_rd2, 16'h00A5);
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
